window_accumulator: RTL and testbench
=====================================

# window_accumulator

Parametrised, multi-channel successor to the single-lane convolution accumulator. It sums exactly `TAPS` accepted input beats per window across `CH` independent lanes. A window is delimited by an internal tap counter, so no external load strobe is used. Each lane can saturate or wrap, and each lane reports overflow. Results are presented through a valid/ready output register to the downstream writer (bias/ReLU or output buffer); the block sits between the MAC array and that writer.

## Interface
Parameters:
- `CH`, 1: number of parallel lanes.
- `IN_W`, 20: unsigned input width per lane.
- `ACC_W`, 24: accumulator/result width per lane; must be ≥ `IN_W`.
- `TAPS`, 9: beats per window; must be ≥ 2.
- `SAT`, 1: 1 = clamp on overflow, 0 = wrap modulo 2^`ACC_W`.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `clear`  in  1: synchronous abort of the current window.
- `in_valid`  in  1: input beat present.
- `in_ready`  out  1: beat accepted when `in_valid && in_ready`.
- `in_data`  in  `CH*IN_W`: lane k at bits [k*IN_W +: IN_W].
- `out_valid`  out  1: result held in the output register.
- `out_ready`  in  1: downstream accepts when `out_valid && out_ready`.
- `out_data`  out  `CH*ACC_W`: lane k at bits [k*ACC_W +: ACC_W].
- `out_ovf`  out  `CH`: per-lane overflow occurred in this window.
- `tap_cnt`  out  `$clog2(TAPS)`: index of the next beat within the window.

## Operation
- Accumulator per lane `acc[k]` (`ACC_W` bits), sticky overflow flag `ovf[k]`, shared tap counter `tap_cnt` in 0..`TAPS`-1.
- Input is zero-extended to `ACC_W`. The sum is computed at `ACC_W`+1 bits; bit `ACC_W` set means overflow.
- Accepted beat with `tap_cnt==0`: `acc[k]` ← `in[k]`, `ovf[k]` ← 0. This load cannot overflow.
- Accepted beat with 0 < `tap_cnt` < `TAPS`-1:
  - `acc[k]` ← sum;
  - on overflow: `SAT=1` clamps to 2^`ACC_W`-1, `SAT=0` keeps the low `ACC_W` bits;
  - `ovf[k]` is OR-ed with the overflow bit in both modes.
- Once `SAT=1` has clamped, subsequent adds stay clamped.
- Accepted beat with `tap_cnt==TAPS-1`:
  - the final sum (same saturation rule) and final `ovf` are written to `out_data`/`out_ovf`;
  - `out_valid` ← 1; `tap_cnt` ← 0.
- `tap_cnt` increments on every accepted non-final beat. Cycles without a beat change nothing.
- `in_ready` = `!rst && !clear && (!out_valid || out_ready)`. This is combinational; every beat stalls while an unaccepted result is held.
- `out_valid` clears on handshake unless a final beat is accepted in the same cycle. In that case the new result replaces the old one, and `out_valid` stays 1.
- `clear`: `tap_cnt`, `acc`, and `ovf` go to 0. Any `in_valid` that cycle is not accepted. `out_valid`, `out_data`, and `out_ovf` are untouched.
- `rst`: every register goes to 0, including `out_valid`, `out_data`, `out_ovf`, and `tap_cnt`. Any partial window in progress is discarded.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_ovf`=0, `tap_cnt`=0. `in_ready`=0 while `rst` is high, and 1 in the first cycle after reset.
- Latency: a final beat accepted at edge N gives `out_valid`=1 with the result after edge N.
- Throughput: one window per `TAPS` cycles with `out_ready` held high. No bubble is inserted between windows.
- `out_data`/`out_ovf` hold stable while `out_valid && !out_ready`.
- Simultaneous `clear` and `rst`: `rst` dominates. Simultaneous `clear` and output handshake: the handshake completes.

## Test plan
Configuration: `CH`=2, `IN_W`=8, `ACC_W`=9, `TAPS`=3 unless noted. Each lane is written as lane0/lane1.
- Basic: beats (1,10),(2,20),(3,30) on consecutive cycles, `out_ready`=1 → one cycle after beat 3, `out_data`=(6,60), `out_ovf`=00, `tap_cnt`=0. Back-to-back windows yield one result every 3 cycles.
- Overflow: lane0 gets 255,255,255 and lane1 gets 1,1,1.
  - `SAT=1` → (511,3), `out_ovf`=01.
  - `SAT=0` → (253,3), `out_ovf`=01.
- Backpressure:
  - Complete a window with `out_ready`=0 → `in_ready`=0, and `out_data` is held for 5 cycles.
  - Raise `out_ready` → handshake, and `in_ready`=1 the same cycle.
  - The next window (4,5,6 on lane0) gives 15.
- Bubbles: beats 7,_,8,_,_,9 (`in_valid` gaps) → lane0 result 24, and `tap_cnt` advances only on accepted beats.
- Clear:
  - Two beats 100,100, then `clear` with `in_valid`=1 → beat not accepted, `tap_cnt`=0.
  - Then beats 1,1,1 → result 3, `ovf`=0. A result held before `clear` is unaffected.
- Reset mid-window: after one beat, assert `rst` for 1 cycle → all outputs 0. A fresh window 2,2,2 then gives 6.

Source files
------------

// File: rtl/window_accumulator.sv
// window_accumulator: sums TAPS accepted beats per window on CH lanes, with saturate or wrap, per-lane overflow and a valid/ready result register
// Ports: clk, rst (sync, active-high), clear (abort window), in_valid/in_ready/in_data (CH*IN_W),
//        out_valid/out_ready/out_data (CH*ACC_W), out_ovf (CH), tap_cnt (index of next beat in window)
module window_accumulator #(
    parameter int CH    = 1,
    parameter int IN_W  = 20,
    parameter int ACC_W = 24,
    parameter int TAPS  = 9,
    parameter bit SAT   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH*IN_W-1:0]       in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH*ACC_W-1:0]      out_data,
    output logic [CH-1:0]            out_ovf,
    output logic [$clog2(TAPS)-1:0]  tap_cnt
);
    localparam int TW = $clog2(TAPS);
    logic [CH-1:0][ACC_W-1:0] acc_q, acc_d, ld_w, res_w, out_data_q, out_data_d;
    logic [CH-1:0]            ovf_q, ovf_d, ob_w, out_ovf_q, out_ovf_d;
    logic [TW-1:0]            tap_q, tap_d;
    logic                     out_valid_q, out_valid_d, fire, last;
    assign in_ready  = !rst && !clear && (!out_valid_q || out_ready);
    assign fire      = in_valid && in_ready;
    assign last      = tap_q == TW'(TAPS - 1);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign tap_cnt   = tap_q;
    for (genvar k = 0; k < CH; k++) begin : g_lane
        logic [ACC_W:0] sum_w;
        assign ld_w[k]  = ACC_W'(in_data[k*IN_W +: IN_W]);
        // one extra bit so the carry out is the overflow indication
        assign sum_w    = {1'b0, acc_q[k]} + (ACC_W+1)'(in_data[k*IN_W +: IN_W]);
        assign ob_w[k]  = sum_w[ACC_W];
        assign res_w[k] = (ob_w[k] && SAT) ? '1 : sum_w[ACC_W-1:0];
    end
    always_comb begin
        acc_d       = clear ? '0 : acc_q;
        ovf_d       = clear ? '0 : ovf_q;
        tap_d       = clear ? '0 : tap_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
        if (fire) begin
            if (tap_q == '0) begin
                acc_d = ld_w;
                ovf_d = '0;
                tap_d = tap_q + 1'b1;
            end else if (!last) begin
                acc_d = res_w;
                ovf_d = ovf_q | ob_w;
                tap_d = tap_q + 1'b1;
            end else begin
                out_data_d  = res_w;
                out_ovf_d   = ovf_q | ob_w;
                out_valid_d = 1'b1;
                tap_d       = '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            ovf_q       <= '0;
            tap_q       <= '0;
            out_data_q  <= '0;
            out_ovf_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            tap_q       <= tap_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_window_accumulator.sv
// tb_window_accumulator: directed checks of window_accumulator in saturating and wrapping builds
module tb_window_accumulator;
    logic        clk = 0, rst = 1, clear = 0, in_valid = 0, out_ready = 1;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid, w_in_ready, w_out_valid;
    logic [17:0] out_data, w_out_data;
    logic [1:0]  out_ovf, w_out_ovf, tap_cnt, w_tap_cnt;
    int          n_run = 0, n_fail = 0;
    always #5 clk = ~clk;
    window_accumulator #(.CH(2), .IN_W(8), .ACC_W(9), .TAPS(3), .SAT(1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .tap_cnt(tap_cnt));
    window_accumulator #(.CH(2), .IN_W(8), .ACC_W(9), .TAPS(3), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data), .out_ovf(w_out_ovf), .tap_cnt(w_tap_cnt));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step(input logic v, input logic [7:0] d0, input logic [7:0] d1);
        in_valid = v;
        in_data  = {d1, d0};
        @(posedge clk);
        #1;
    endtask
    task automatic check_out(input string tag, input int l0, input int l1, input int ovf);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_l0"}, 32'(out_data[8:0]), l0);
        check({tag, "_l1"}, 32'(out_data[17:9]), l1);
        check({tag, "_ovf"}, 32'(out_ovf), ovf);
    endtask
    initial begin
        step(0, 0, 0);
        check("rst_in_ready", 32'(in_ready), 0);
        step(0, 0, 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_ovf", 32'(out_ovf), 0);
        check("rst_tap", 32'(tap_cnt), 0);
        rst = 0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        step(1, 1, 10);
        check("basic_tap1", 32'(tap_cnt), 1);
        step(1, 2, 20);
        check("basic_tap2", 32'(tap_cnt), 2);
        check("basic_not_yet", 32'(out_valid), 0);
        step(1, 3, 30);
        check_out("basic", 6, 60, 0);
        check("basic_tap0", 32'(tap_cnt), 0);
        step(1, 1, 1);
        check("b2b_hs", 32'(out_valid), 0);
        step(1, 1, 1);
        step(1, 2, 2);
        check_out("b2b_w2", 4, 4, 0);
        step(1, 5, 0);
        step(1, 5, 0);
        step(1, 5, 0);
        check_out("b2b_w3", 15, 0, 0);
        step(1, 255, 1);
        step(1, 255, 1);
        check("ovf_mid_valid", 32'(out_valid), 0);
        step(1, 255, 1);
        check_out("ovf_sat", 511, 3, 1);
        check("ovf_wrap_l0", 32'(w_out_data[8:0]), 253);
        check("ovf_wrap_l1", 32'(w_out_data[17:9]), 3);
        check("ovf_wrap_ovf", 32'(w_out_ovf), 1);
        step(0, 0, 0);
        check("bp_pre_hs", 32'(out_valid), 0);
        out_ready = 0;
        step(1, 9, 9);
        step(1, 9, 9);
        step(1, 9, 9);
        check_out("bp_res", 27, 27, 0);
        check("bp_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 4, 0);
            check($sformatf("bp_hold%0d_l0", i), 32'(out_data[8:0]), 27);
            check($sformatf("bp_hold%0d_rdy", i), 32'(in_ready), 0);
            check($sformatf("bp_hold%0d_tap", i), 32'(tap_cnt), 0);
        end
        out_ready = 1;
        #1;
        check("bp_release_rdy", 32'(in_ready), 1);
        step(1, 4, 0);
        check("bp_hs_valid", 32'(out_valid), 0);
        check("bp_hs_tap", 32'(tap_cnt), 1);
        step(1, 5, 0);
        step(1, 6, 0);
        check_out("bp_next", 15, 0, 0);
        step(1, 7, 0);
        check("bub_tap_a", 32'(tap_cnt), 1);
        step(0, 99, 0);
        check("bub_tap_b", 32'(tap_cnt), 1);
        step(1, 8, 0);
        check("bub_tap_c", 32'(tap_cnt), 2);
        step(0, 99, 0);
        step(0, 99, 0);
        check("bub_tap_d", 32'(tap_cnt), 2);
        step(1, 9, 0);
        check_out("bub", 24, 0, 0);
        out_ready = 0;
        clear = 1;
        step(1, 50, 50);
        check_out("clr_held", 24, 0, 0);
        clear = 0;
        out_ready = 1;
        step(1, 100, 0);
        step(1, 100, 0);
        check("clr_tap_pre", 32'(tap_cnt), 2);
        clear = 1;
        in_valid = 1;
        #1;
        check("clr_in_ready", 32'(in_ready), 0);
        step(1, 50, 50);
        check("clr_tap", 32'(tap_cnt), 0);
        check("clr_no_result", 32'(out_valid), 0);
        clear = 0;
        step(1, 1, 1);
        step(1, 1, 1);
        step(1, 1, 1);
        check_out("clr_after", 3, 3, 0);
        step(1, 5, 5);
        check("mid_tap", 32'(tap_cnt), 1);
        rst = 1;
        step(0, 0, 0);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data", 32'(out_data), 0);
        check("mid_rst_ovf", 32'(out_ovf), 0);
        check("mid_rst_tap", 32'(tap_cnt), 0);
        rst = 0;
        step(1, 2, 2);
        step(1, 2, 2);
        step(1, 2, 2);
        check_out("mid_fresh", 6, 6, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
